exec_ctrl_unit: RTL and testbench



---
 rtl/exec_ctrl_unit.sv | 187 ++++++++++++++++++
 tb/tb_exec_ctrl_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl_unit.sv
// RV32I single-cycle control/execute slice: decode, ALU, branch resolution, next-PC.
// Everything is combinational except the sticky illegal-instruction flag.
module exec_ctrl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic [2:0]  ext_op,
    output logic        reg_wr,
    output logic        mem_to_reg,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  mem_op,
    output logic [31:0] alu_out,
    output logic [31:0] next_pc,
    output logic        illegal,
    output logic        illegal_seen
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    logic        a_src;
    logic [1:0]  b_src;
    logic [3:0]  alu_ctr;
    logic [2:0]  branch;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  shamt;
    logic        less, zero;
    logic        pc_a_src, pc_b_src;
    logic        illegal_seen_q, illegal_seen_d;

    // sub_en applies to func3 000, sra_en to func3 101.
    function automatic logic [3:0] f3_ctr(input logic [2:0] f3, input logic sub_en,
                                          input logic sra_en);
        case (f3)
            3'b000:  f3_ctr = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  f3_ctr = ALU_SLL;
            3'b010:  f3_ctr = ALU_SLT;
            3'b011:  f3_ctr = ALU_SLTU;
            3'b100:  f3_ctr = ALU_XOR;
            3'b101:  f3_ctr = sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  f3_ctr = ALU_OR;
            default: f3_ctr = ALU_AND;
        endcase
    endfunction

    always_comb begin
        ext_op     = 3'b000;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_op     = 3'b000;
        a_src      = 1'b0;
        b_src      = 2'b00;
        alu_ctr    = ALU_ADD;
        branch     = 3'b000;
        illegal    = 1'b0;
        case (op)
            OP_LUI: begin
                ext_op = 3'b001; reg_wr = 1'b1; b_src = 2'b01; alu_ctr = ALU_PASS;
            end
            OP_AUIPC: begin
                ext_op = 3'b001; reg_wr = 1'b1; a_src = 1'b1; b_src = 2'b01;
            end
            OP_JAL: begin
                ext_op = 3'b100; reg_wr = 1'b1; a_src = 1'b1; b_src = 2'b10; branch = 3'b001;
            end
            OP_JALR: begin
                ext_op = 3'b000; reg_wr = 1'b1; a_src = 1'b1; b_src = 2'b10; branch = 3'b010;
                illegal = (func3 != 3'b000);
            end
            OP_BRANCH: begin
                ext_op = 3'b011;
                case (func3)
                    3'b000:  begin branch = 3'b100; alu_ctr = ALU_SLT;  end
                    3'b001:  begin branch = 3'b101; alu_ctr = ALU_SLT;  end
                    3'b100:  begin branch = 3'b110; alu_ctr = ALU_SLT;  end
                    3'b101:  begin branch = 3'b111; alu_ctr = ALU_SLT;  end
                    3'b110:  begin branch = 3'b110; alu_ctr = ALU_SLTU; end
                    3'b111:  begin branch = 3'b111; alu_ctr = ALU_SLTU; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                reg_wr = 1'b1; mem_to_reg = 1'b1; mem_rd = 1'b1; b_src = 2'b01; mem_op = func3;
                illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
            end
            OP_STORE: begin
                ext_op = 3'b010; mem_wr = 1'b1; b_src = 2'b01; mem_op = func3;
                illegal = (func3[2] || (func3[1:0] == 2'b11));
            end
            OP_IMM: begin
                reg_wr = 1'b1; b_src = 2'b01; alu_ctr = f3_ctr(func3, 1'b0, func7[5]);
            end
            OP_REG: begin
                reg_wr = 1'b1; alu_ctr = f3_ctr(func3, func7[5], func7[5]);
                illegal = (func7 != 7'b0000000) && (func7 != 7'b0100000);
            end
            default: illegal = 1'b1;
        endcase
        // An unsupported encoding must not disturb architectural state.
        if (illegal) begin
            ext_op = 3'b000; reg_wr = 1'b0; mem_to_reg = 1'b0; mem_rd = 1'b0;
            mem_wr = 1'b0; mem_op = 3'b000; alu_ctr = ALU_ADD; branch = 3'b000;
        end
    end

    assign alu_a = a_src ? pc : rs1_data;
    always_comb begin
        case (b_src)
            2'b00:   alu_b = rs2_data;
            2'b01:   alu_b = imm;
            2'b10:   alu_b = 32'd4;
            default: alu_b = 32'd0;
        endcase
    end

    assign shamt = alu_b[4:0];
    assign zero  = (alu_a == alu_b);
    assign less  = alu_ctr[3] ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));

    always_comb begin
        case (alu_ctr)
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_SLL:  alu_out = alu_a << shamt;
            ALU_SRL:  alu_out = alu_a >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(alu_a) >>> shamt);
            ALU_SLT:  alu_out = {31'd0, less};
            ALU_SLTU: alu_out = {31'd0, less};
            ALU_PASS: alu_out = alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_AND:  alu_out = alu_a & alu_b;
            default:  alu_out = 32'd0;
        endcase
    end

    always_comb begin
        pc_a_src = 1'b0;
        pc_b_src = 1'b0;
        case (branch)
            3'b001:  pc_a_src = 1'b1;
            3'b010:  begin pc_a_src = 1'b1; pc_b_src = 1'b1; end
            3'b100:  pc_a_src = zero;
            3'b101:  pc_a_src = ~zero;
            3'b110:  pc_a_src = less;
            3'b111:  pc_a_src = ~less;
            default: pc_a_src = 1'b0;
        endcase
    end

    // jalr target keeps bit 0 as computed.
    assign next_pc = (pc_a_src ? imm : 32'd4) + (pc_b_src ? rs1_data : pc);

    assign illegal_seen_d = illegal_seen_q | illegal;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal_seen_q <= 1'b0;
        else      illegal_seen_q <= illegal_seen_d;
    end
    assign illegal_seen = illegal_seen_q;
endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed bench for exec_ctrl_unit: hand-computed vectors checked with immediate assertions.
module tb_exec_ctrl_unit;
    logic        clk, rst;
    logic [6:0]  op, func7;
    logic [2:0]  func3;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [2:0]  ext_op, mem_op;
    logic        reg_wr, mem_to_reg, mem_rd, mem_wr, illegal, illegal_seen;
    logic [31:0] alu_out, next_pc;
    int          checks = 0;
    int          errors = 0;

    exec_ctrl_unit dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .ext_op(ext_op),
        .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_op(mem_op), .alu_out(alu_out), .next_pc(next_pc), .illegal(illegal),
        .illegal_seen(illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        op = o; func3 = f3; func7 = f7; pc = p; rs1_data = a; rs2_data = b; imm = im;
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {illegal, reg_wr, mem_to_reg, mem_rd, mem_wr, ext_op, mem_op}.
    task automatic chk_ctl(input string tag, input logic ill, input logic rw, input logic m2r,
                           input logic mrd, input logic mwr, input logic [2:0] ext,
                           input logic [2:0] mop);
        chk(tag, {21'd0, illegal, reg_wr, mem_to_reg, mem_rd, mem_wr, ext_op, mem_op},
                 {21'd0, ill, rw, m2r, mrd, mwr, ext, mop});
    endtask

    initial begin
        rst = 1'b0;
        apply(7'b0010011, 3'b000, 7'h00, 32'h1000, 32'd5, 32'd0, 32'hFFFF_FFFF);
        chk("reset_seen", {31'd0, illegal_seen}, 32'd0);
        @(negedge clk); rst = 1'b1;

        apply(7'b0010011, 3'b000, 7'h00, 32'h1000, 32'd5, 32'd0, 32'hFFFF_FFFF);
        chk("addi_alu", alu_out, 32'd4);
        chk("addi_npc", next_pc, 32'h1004);
        chk_ctl("addi_ctl", 0, 1, 0, 0, 0, 3'b000, 3'b000);

        apply(7'b0110111, 3'b000, 7'h00, 32'h1000, 32'h55, 32'h66, 32'h1234_5000);
        chk("lui_alu", alu_out, 32'h1234_5000);
        chk_ctl("lui_ctl", 0, 1, 0, 0, 0, 3'b001, 3'b000);

        apply(7'b0010111, 3'b000, 7'h00, 32'h1000, 32'h55, 32'h66, 32'h2000);
        chk("auipc_alu", alu_out, 32'h3000);

        apply(7'b0110011, 3'b000, 7'h20, 32'h0, 32'h8000_0000, 32'd4, 32'h0);
        chk("sub_alu", alu_out, 32'h7FFF_FFFC);
        apply(7'b0110011, 3'b101, 7'h20, 32'h0, 32'h8000_0000, 32'd4, 32'h0);
        chk("sra_alu", alu_out, 32'hF800_0000);
        apply(7'b0110011, 3'b101, 7'h00, 32'h0, 32'h8000_0000, 32'd4, 32'h0);
        chk("srl_alu", alu_out, 32'h0800_0000);
        apply(7'b0110011, 3'b001, 7'h00, 32'h0, 32'h0000_0003, 32'd4, 32'h0);
        chk("sll_alu", alu_out, 32'h0000_0030);
        apply(7'b0110011, 3'b010, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        chk("slt_alu", alu_out, 32'd1);
        apply(7'b0110011, 3'b011, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        chk("sltu_alu", alu_out, 32'd0);
        apply(7'b0110011, 3'b111, 7'h00, 32'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0);
        chk("and_alu", alu_out, 32'h00F0_000F);
        apply(7'b0110011, 3'b110, 7'h00, 32'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0);
        chk("or_alu", alu_out, 32'hFFF0_0FFF);
        apply(7'b0110011, 3'b000, 7'h01, 32'h2000, 32'd1, 32'd2, 32'h0);
        chk_ctl("op_badf7_ctl", 1, 0, 0, 0, 0, 3'b000, 3'b000);
        chk("op_badf7_npc", next_pc, 32'h2004);

        apply(7'b0010011, 3'b101, 7'h20, 32'h0, 32'h8000_0000, 32'd0, 32'h0000_0404);
        chk("srai_alu", alu_out, 32'hF800_0000);
        apply(7'b0010011, 3'b100, 7'h00, 32'h0, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFF);
        chk("xori_alu", alu_out, 32'h0F0F_0F0F);

        apply(7'b1100011, 3'b100, 7'h00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd16);
        chk("blt_npc", next_pc, 32'h8000_0010);
        chk_ctl("blt_ctl", 0, 0, 0, 0, 0, 3'b011, 3'b000);
        apply(7'b1100011, 3'b110, 7'h00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd16);
        chk("bltu_npc", next_pc, 32'h8000_0004);
        apply(7'b1100011, 3'b101, 7'h00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd16);
        chk("bge_npc", next_pc, 32'h8000_0004);
        apply(7'b1100011, 3'b111, 7'h00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd16);
        chk("bgeu_npc", next_pc, 32'h8000_0010);
        apply(7'b1100011, 3'b000, 7'h00, 32'h100, 32'd7, 32'd7, 32'h40);
        chk("beq_taken_npc", next_pc, 32'h140);
        apply(7'b1100011, 3'b001, 7'h00, 32'h100, 32'd7, 32'd7, 32'h40);
        chk("bne_not_npc", next_pc, 32'h104);
        apply(7'b1100011, 3'b001, 7'h00, 32'h100, 32'd7, 32'd8, 32'h40);
        chk("bne_taken_npc", next_pc, 32'h140);
        apply(7'b1100011, 3'b010, 7'h00, 32'h100, 32'd7, 32'd7, 32'h40);
        chk_ctl("br010_ctl", 1, 0, 0, 0, 0, 3'b000, 3'b000);
        chk("br010_npc", next_pc, 32'h104);

        apply(7'b1101111, 3'b000, 7'h00, 32'h1000, 32'h0, 32'h0, 32'h20);
        chk("jal_npc", next_pc, 32'h1020);
        chk("jal_alu", alu_out, 32'h1004);
        chk_ctl("jal_ctl", 0, 1, 0, 0, 0, 3'b100, 3'b000);
        apply(7'b1100111, 3'b000, 7'h00, 32'h8000_0000, 32'h8000_1000, 32'h0, 32'd8);
        chk("jalr_npc", next_pc, 32'h8000_1008);
        chk("jalr_alu", alu_out, 32'h8000_0004);
        apply(7'b1100111, 3'b000, 7'h00, 32'h8000_0000, 32'h8000_1000, 32'h0, 32'd7);
        chk("jalr_odd_npc", next_pc, 32'h8000_1007);
        apply(7'b1100111, 3'b001, 7'h00, 32'h8000_0000, 32'h8000_1000, 32'h0, 32'd8);
        chk_ctl("jalr_f3_ctl", 1, 0, 0, 0, 0, 3'b000, 3'b000);
        chk("jalr_f3_npc", next_pc, 32'h8000_0004);

        apply(7'b0000011, 3'b010, 7'h00, 32'h400, 32'h100, 32'h0, 32'd4);
        chk("lw_alu", alu_out, 32'h104);
        chk_ctl("lw_ctl", 0, 1, 1, 1, 0, 3'b000, 3'b010);
        apply(7'b0000011, 3'b101, 7'h00, 32'h400, 32'h100, 32'h0, 32'd2);
        chk_ctl("lhu_ctl", 0, 1, 1, 1, 0, 3'b000, 3'b101);
        apply(7'b0000011, 3'b011, 7'h00, 32'h400, 32'h100, 32'h0, 32'd4);
        chk_ctl("ld_ctl", 1, 0, 0, 0, 0, 3'b000, 3'b000);
        apply(7'b0100011, 3'b010, 7'h00, 32'h400, 32'h100, 32'h0, 32'hC);
        chk("sw_alu", alu_out, 32'h10C);
        chk_ctl("sw_ctl", 0, 0, 0, 0, 1, 3'b010, 3'b010);
        chk("sw_npc", next_pc, 32'h404);
        apply(7'b0100011, 3'b100, 7'h00, 32'h400, 32'h100, 32'h0, 32'hC);
        chk_ctl("s100_ctl", 1, 0, 0, 0, 0, 3'b000, 3'b000);

        // Sticky flag sequence, aligned to the clock.
        @(negedge clk); rst = 1'b0; #1;
        chk("seen_clr", {31'd0, illegal_seen}, 32'd0);
        rst = 1'b1;
        apply(7'b0010011, 3'b000, 7'h00, 32'h1000, 32'd1, 32'd0, 32'd1);
        @(posedge clk); #1;
        chk("seen_legal", {31'd0, illegal_seen}, 32'd0);
        @(negedge clk);
        apply(7'b0000000, 3'b000, 7'h00, 32'h3000, 32'd3, 32'd4, 32'h0);
        chk_ctl("ill_ctl", 1, 0, 0, 0, 0, 3'b000, 3'b000);
        chk("ill_npc", next_pc, 32'h3004);
        chk("seen_pre_edge", {31'd0, illegal_seen}, 32'd0);
        @(posedge clk); #1;
        chk("seen_set", {31'd0, illegal_seen}, 32'd1);
        apply(7'b0010011, 3'b000, 7'h00, 32'h1000, 32'd1, 32'd0, 32'd1);
        @(posedge clk); #1;
        chk("seen_hold", {31'd0, illegal_seen}, 32'd1);
        @(negedge clk); #1; rst = 1'b0; #1;
        chk("seen_async_clr", {31'd0, illegal_seen}, 32'd0);
        apply(7'b0000000, 3'b000, 7'h00, 32'h3000, 32'd3, 32'd4, 32'h0);
        @(posedge clk); #1;
        chk("seen_in_reset", {31'd0, illegal_seen}, 32'd0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
